// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: stage tags, forward selects, FSM states.
// Tag rd fields are TAG_AW wide so any RF_AW up to TAG_AW fits.
package hazard_pkg;

    localparam int unsigned TAG_AW = 8;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] rd;
        logic              we;
        logic              is_load;
        logic              mem_op;
    } stage_tag_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    // r0 is hardwired to zero, so it never creates a dependence.
    function automatic logic tag_match(input stage_tag_t t, input logic [TAG_AW-1:0] rs);
        return t.valid && t.we && (t.rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Per-operand match/priority logic against the EX, MEM and WB shadow tags.
// HAZARD_FWD_EN selects forwarding; otherwise every EX/MEM dependence stalls.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned RF_AW = 5
) (
    input  logic [RF_AW-1:0] rs,
    input  stage_tag_t       ex_t,
    input  stage_tag_t       mem_t,
    input  stage_tag_t       wb_t,
    output fwd_sel_e         sel,
    output logic             hazard
);

    logic [TAG_AW-1:0] rs_ext;
    logic              ex_hit;
    logic              mem_hit;
    logic              unused_tag;

    assign rs_ext     = TAG_AW'(rs);
    assign ex_hit     = tag_match(ex_t, rs_ext);
    assign mem_hit    = tag_match(mem_t, rs_ext);
    assign unused_tag = ^{ex_t, mem_t, wb_t};

`ifdef HAZARD_FWD_EN
    logic wb_hit;

    assign wb_hit = tag_match(wb_t, rs_ext);

    always_comb begin
        hazard = ex_hit && ex_t.is_load;
        sel    = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end
`else
    // Write-before-read register file makes a WB match harmless.
    always_comb begin
        hazard = ex_hit || mem_hit;
        sel    = FWD_RF;
    end
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage core with a MEM-wait hold FSM.
// Build with HAZARD_FWD_EN for operand forwarding; without it dependences stall instead.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RF_AW-1:0] id_rs1,
    input  logic [RF_AW-1:0] id_rs2,
    input  logic [RF_AW-1:0] id_rd,
    input  logic             id_rf_we,
    input  logic             id_is_load,
    input  logic             id_mem_op,
    input  logic             ex_br_taken,
    input  logic             dmem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_all,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [31:0]      stall_cnt
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    stage_tag_t  ex_q;
    stage_tag_t  mem_q;
    stage_tag_t  wb_q;
    stage_tag_t  id_tag;
    fwd_sel_e    sel1;
    fwd_sel_e    sel2;
    logic        haz1;
    logic        haz2;
    logic [31:0] cnt_q;

    fwd_unit #(
        .RF_AW (RF_AW)
    ) u_fwd1 (
        .rs     (id_rs1),
        .ex_t   (ex_q),
        .mem_t  (mem_q),
        .wb_t   (wb_q),
        .sel    (sel1),
        .hazard (haz1)
    );

    fwd_unit #(
        .RF_AW (RF_AW)
    ) u_fwd2 (
        .rs     (id_rs2),
        .ex_t   (ex_q),
        .mem_t  (mem_q),
        .wb_t   (wb_q),
        .sel    (sel2),
        .hazard (haz2)
    );

    always_comb begin
        state_d   = state_q;
        stall_all = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_q.mem_op && !dmem_ready) begin
                    stall_all = 1'b1;
                    state_d   = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else begin
                    stall_all = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        // A held branch is honoured on the first unfrozen cycle and beats load-use.
        if (!stall_all) begin
            if (ex_br_taken) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (haz1 || haz2) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end
        end
    end

    always_comb begin
        id_tag = '0;
        if (id_valid && !stall_id && !flush_ex) begin
            id_tag.valid   = 1'b1;
            id_tag.rd      = TAG_AW'(id_rd);
            id_tag.we      = id_rf_we;
            id_tag.is_load = id_is_load;
            id_tag.mem_op  = id_mem_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (!stall_all) begin
                ex_q  <= id_tag;
                mem_q <= ex_q;
                wb_q  <= mem_q;
            end
            if (stall_all || stall_id) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign fwd_sel1  = sel1;
    assign fwd_sel2  = sel2;
    assign stall_cnt = cnt_q;

endmodule
